// File: rtl/regfile_mp_scoreboard.sv
// Multi-read-port integer register file with write-to-read bypass, a per-register busy
// scoreboard, and a reset-time clear sequencer so the storage needs no reset of its own.
module regfile_mp_scoreboard #(
  parameter int unsigned XLEN     = 32,
  parameter int unsigned NREGS    = 32,
  parameter int unsigned NREAD    = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                              clk,
  input  logic                              reset,
  output logic                              ready,
  input  logic [NREAD*$clog2(NREGS)-1:0]    rd_addr,
  output logic [NREAD*XLEN-1:0]             rd_data,
  output logic [NREAD-1:0]                  rd_busy,
  input  logic                              wr_en,
  input  logic [$clog2(NREGS)-1:0]          wr_addr,
  input  logic [XLEN-1:0]                   wr_data,
  input  logic                              claim_en,
  input  logic [$clog2(NREGS)-1:0]          claim_addr
);

  localparam int unsigned AW = $clog2(NREGS);

  typedef enum logic [0:0] {StClear, StReady} state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         clr_ptr_q;
  logic [XLEN-1:0]       mem [NREGS];
  logic [NREGS-1:0]      busy_q, busy_d;
  logic                  clr_last;
  logic                  wr_eff, claim_eff;
  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [XLEN-1:0]       mem_wdata;
  logic [NREAD*XLEN-1:0] rd_data_d;
  logic [NREAD-1:0]      rd_busy_d;

  // Address maps to a real, writable register (excludes hardwired zero and out-of-range).
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (32'(a) < NREGS) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign clr_last = (clr_ptr_q == AW'(NREGS - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= StClear;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if ((state_q == StClear) && clr_last) state_d = StReady;
  end

  // The clear sequencer and writeback share the single storage write port.
  always_comb begin
    wr_eff    = 1'b0;
    claim_eff = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    unique case (state_q)
      StClear: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = '0;
      end
      StReady: begin
        wr_eff    = wr_en && addr_ok(wr_addr);
        claim_eff = claim_en && addr_ok(claim_addr);
        mem_we    = wr_eff;
      end
      default: ;
    endcase
  end

  // Claim is applied after the clear so a new producer wins on a same-edge collision.
  always_comb begin
    busy_d = busy_q;
    if (wr_eff)    busy_d[wr_addr]    = 1'b0;
    if (claim_eff) busy_d[claim_addr] = 1'b1;
  end

  always_comb begin
    rd_data_d = '0;
    rd_busy_d = '0;
    if (state_q == StReady) begin
      for (int i = 0; i < NREAD; i++) begin
        if (addr_ok(rd_addr[i*AW +: AW])) begin
          if (wr_eff && (wr_addr == rd_addr[i*AW +: AW])) begin
            rd_data_d[i*XLEN +: XLEN] = wr_data;
          end else begin
            rd_data_d[i*XLEN +: XLEN] = mem[rd_addr[i*AW +: AW]];
          end
          rd_busy_d[i] = busy_d[rd_addr[i*AW +: AW]];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      clr_ptr_q <= AW'(ZERO_REG);
      busy_q    <= '0;
      ready     <= 1'b0;
      rd_data   <= '0;
      rd_busy   <= '0;
    end else begin
      if (state_q == StClear) clr_ptr_q <= clr_ptr_q + AW'(1);
      busy_q  <= busy_d;
      ready   <= (state_d == StReady);
      rd_data <= rd_data_d;
      rd_busy <= rd_busy_d;
    end
  end

  // No reset on the array so it can map to block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_regfile_mp_scoreboard.sv
// Directed bench for regfile_mp_scoreboard; the driver queues expected outputs per cycle
// and an independent monitor pops and compares them one cycle later.
module tb_regfile_mp_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic        ready;
  logic [19:0] rd_addr;
  logic [127:0] rd_data;
  logic [3:0]  rd_busy;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        claim_en;
  logic [4:0]  claim_addr;

  regfile_mp_scoreboard dut (
    .clk        (clk),
    .reset      (reset),
    .ready      (ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_busy    (rd_busy),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .claim_en   (claim_en),
    .claim_addr (claim_addr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // port < 0 means a check of the ready output (data[0]).
  typedef struct {
    int          due;
    int          port;
    logic [31:0] data;
    logic        busy;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic exp_port(input int p, input logic [31:0] d, input logic b, input string nm);
    exp_t e;
    e.due = cyc + 1; e.port = p; e.data = d; e.busy = b; e.name = nm;
    sb.push_back(e);
  endtask

  task automatic exp_all(input logic [31:0] d, input logic b, input string nm);
    for (int p = 0; p < 4; p++) exp_port(p, d, b, nm);
  endtask

  task automatic exp_ready(input logic r, input string nm);
    exp_port(-1, {31'd0, r}, 1'b0, nm);
  endtask

  task automatic set_rd(input int p, input int a);
    rd_addr[p*5 +: 5] = 5'(a);
  endtask

  task automatic set_all_rd(input int a);
    for (int p = 0; p < 4; p++) set_rd(p, a);
  endtask

  task automatic tick();
    @(negedge clk);
    wr_en    = 1'b0;
    claim_en = 1'b0;
  endtask

  task automatic do_write(input int a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = 5'(a); wr_data = d;
  endtask

  task automatic do_claim(input int a);
    claim_en = 1'b1; claim_addr = 5'(a);
  endtask

  // Clear sequence after reset release: ready must rise on the 31st posedge.
  task automatic clear_seq(input bit poke);
    for (int k = 1; k <= 31; k++) begin
      set_all_rd(k);
      if (poke && k == 20) begin
        do_write(9, 32'h0000_0099);
        do_claim(9);
      end
      exp_ready(k == 31, "clr_ready");
      exp_port(0, 32'd0, 1'b0, "clr_rd_zero");
      tick();
    end
  endtask

  exp_t m;
  always @(posedge clk) begin
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      m = sb.pop_front();
      n_checks++;
      if (m.due != cyc) begin
        n_fail++;
        $display("FAIL %s: check for cycle %0d evaluated at cycle %0d", m.name, m.due, cyc);
      end else if (m.port < 0) begin
        if (ready !== m.data[0]) begin
          n_fail++;
          $display("FAIL %s: cycle %0d ready got %b expected %b", m.name, cyc, ready,
                   m.data[0]);
        end
      end else if (rd_data[m.port*32 +: 32] !== m.data || rd_busy[m.port] !== m.busy) begin
        n_fail++;
        $display("FAIL %s: cycle %0d port %0d got data=%h busy=%b expected data=%h busy=%b",
                 m.name, cyc, m.port, rd_data[m.port*32 +: 32], rd_busy[m.port], m.data,
                 m.busy);
      end
    end
  end

  initial begin
    reset = 1'b1; rd_addr = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    claim_en = 1'b0; claim_addr = '0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      exp_ready(1'b0, "rst_ready");
      exp_all(32'd0, 1'b0, "rst_rd");
      tick();
    end
    reset = 1'b0;
    clear_seq(1'b0);

    for (int r = 0; r < 32; r++) begin
      set_all_rd(r);
      exp_all(32'd0, 1'b0, "init_zero");
      tick();
    end

    // Write then read next cycle
    set_all_rd(0);
    do_write(1, 32'hDEAD_BEEF);
    exp_port(0, 32'd0, 1'b0, "wr_x1_rd_x0");
    tick();
    set_rd(0, 1);
    exp_port(0, 32'hDEAD_BEEF, 1'b0, "rd_x1");
    tick();

    // Same-edge bypass
    set_rd(0, 1); set_rd(2, 5);
    do_write(5, 32'h1234_5678);
    exp_port(2, 32'h1234_5678, 1'b0, "bypass_x5");
    exp_port(0, 32'hDEAD_BEEF, 1'b0, "rd_x1_again");
    tick();
    exp_port(2, 32'h1234_5678, 1'b0, "rd_x5_stored");
    tick();

    // x0 hardwired
    set_all_rd(0);
    do_write(0, 32'hFFFF_FFFF);
    do_claim(0);
    exp_all(32'd0, 1'b0, "x0_same_edge");
    tick();
    exp_all(32'd0, 1'b0, "x0_after");
    tick();

    // Scoreboard
    set_all_rd(7);
    do_claim(7);
    exp_all(32'd0, 1'b1, "claim_x7");
    tick();
    exp_port(1, 32'd0, 1'b1, "x7_still_busy");
    tick();
    do_write(7, 32'h0000_00A5);
    exp_all(32'h0000_00A5, 1'b0, "wr_x7_clears");
    tick();
    do_write(7, 32'h0000_005A);
    do_claim(7);
    exp_all(32'h0000_005A, 1'b1, "claim_wr_x7");
    tick();
    exp_port(3, 32'h0000_005A, 1'b1, "x7_held");
    tick();

    // Reset mid-operation and mid-clear
    do_write(3, 32'h0000_0033);
    tick();
    do_claim(4);
    set_rd(1, 3);
    exp_port(1, 32'h0000_0033, 1'b0, "rd_x3");
    tick();
    set_rd(3, 4);
    exp_port(3, 32'd0, 1'b1, "x4_busy");
    tick();
    reset = 1'b1;
    exp_ready(1'b0, "rst2_ready");
    exp_all(32'd0, 1'b0, "rst2_rd");
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      exp_ready(1'b0, "partial_clr");
      tick();
    end
    reset = 1'b1;
    exp_ready(1'b0, "rst3_ready");
    tick();
    reset = 1'b0;
    clear_seq(1'b1);
    set_rd(0, 3); set_rd(1, 4); set_rd(2, 9); set_rd(3, 7);
    exp_all(32'd0, 1'b0, "after_reclear");
    exp_ready(1'b1, "ready_held");
    tick();

    for (int i = 0; i < 5 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
